// File: rtl/readout_sequencer_pkg.sv
// Shared types and constants for the readout sequencer: FSM state encoding,
// SPI opcode values and the default channel count.
package psec5_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_WAIT = 2'd2,
    ST_DONE = 2'd3
  } seq_state_e;

  localparam logic [7:0] OP_START   = 8'h01;
  localparam logic [7:0] OP_ABORT   = 8'h02;
  localparam int         NUM_CH_DEF = 8;

  // Channel select width; a single-channel build still needs one bit.
  function automatic int sel_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/readout_sequencer_if.sv
// Control/serializer bus of the readout sequencer, with master (register map
// plus serializer side) and slave (sequencer) modports.
interface readout_sequencer_if #(
  parameter int NUM_CH = psec5_seq_pkg::NUM_CH_DEF
) ();
  localparam int SEL_W = psec5_seq_pkg::sel_width(NUM_CH);

  // instr_valid is a one-cycle strobe qualifying instruction; ser_done is a
  // level sampled every cycle and only acted on while the sequencer waits.
  logic [7:0]        instruction;
  logic              instr_valid;
  logic [NUM_CH-1:0] trigger_channel_mask;
  logic [7:0]        mode;
  logic              ser_done;
  logic [NUM_CH-1:0] load_cnt_ser;
  logic [SEL_W-1:0]  select_reg;
  logic              busy;
  logic              seq_done;
  logic              timeout_err;

  modport master (
    output instruction, instr_valid, trigger_channel_mask, mode, ser_done,
    input  load_cnt_ser, select_reg, busy, seq_done, timeout_err
  );

  modport slave (
    input  instruction, instr_valid, trigger_channel_mask, mode, ser_done,
    output load_cnt_ser, select_reg, busy, seq_done, timeout_err
  );

endinterface

// File: rtl/readout_sequencer_chan_prio_find.sv
// Combinational search for the lowest set mask bit strictly above from_idx;
// from_none makes the search start at bit 0.
module chan_prio_find #(
  parameter int NUM_CH = 8,
  parameter int SEL_W  = 3
) (
  input  logic [NUM_CH-1:0] mask,
  input  logic [SEL_W-1:0]  from_idx,
  input  logic              from_none,
  output logic [SEL_W-1:0]  idx,
  output logic              found
);

  // Descending walk so the lowest qualifying bit is the last one written.
  always_comb begin
    idx   = '0;
    found = 1'b0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (mask[i] && (from_none || (i > int'(from_idx)))) begin
        idx   = SEL_W'(i);
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/readout_sequencer.sv
// Channel readout sequencer: scans enabled channels in ascending order, loading
// each counter into the serializer. Optional WAIT watchdog under SEQ_TIMEOUT_EN.
module readout_sequencer
  import psec5_seq_pkg::*;
#(
  parameter int NUM_CH         = NUM_CH_DEF,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic               iclk,
  input  logic               rstn,
  readout_sequencer_if.slave bus,
  output seq_state_e         dbg_state
);

  localparam int SEL_W = sel_width(NUM_CH);

  seq_state_e        state_q, state_d;
  logic [NUM_CH-1:0] mask_q, mask_d;
  logic [SEL_W-1:0]  sel_q, sel_d;
  logic              start_cmd, abort_cmd;
  logic              timeout_set, timeout_clr, expire;
  logic              search_fresh;
  logic [NUM_CH-1:0] search_mask;
  logic [SEL_W-1:0]  next_idx;
  logic              next_found;
  logic              unused_ok;

  assign start_cmd = bus.instr_valid && (bus.instruction == OP_START);
  assign abort_cmd = bus.instr_valid && (bus.instruction == OP_ABORT);

  // IDLE and DONE look at the live mask (new snapshot); LOAD/WAIT walk the snapshot.
  assign search_fresh = (state_q == ST_IDLE) || (state_q == ST_DONE);
  assign search_mask  = search_fresh ? bus.trigger_channel_mask : mask_q;

  chan_prio_find #(
    .NUM_CH (NUM_CH),
    .SEL_W  (SEL_W)
  ) u_find (
    .mask      (search_mask),
    .from_idx  (sel_q),
    .from_none (search_fresh),
    .idx       (next_idx),
    .found     (next_found)
  );

  always_ff @(posedge iclk) begin
    if (!rstn) begin
      state_q <= ST_IDLE;
      mask_q  <= '0;
      sel_q   <= '0;
    end else begin
      state_q <= state_d;
      mask_q  <= mask_d;
      sel_q   <= sel_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    mask_d      = mask_q;
    sel_d       = sel_q;
    timeout_set = 1'b0;
    timeout_clr = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start_cmd) begin
          mask_d      = bus.trigger_channel_mask;
          timeout_clr = 1'b1;
          if (next_found) begin
            state_d = ST_LOAD;
            sel_d   = next_idx;
          end else begin
            state_d = ST_DONE;
          end
        end
      end
      ST_LOAD: state_d = ST_WAIT;
      ST_WAIT: begin
        if (bus.ser_done) begin
          if (next_found) begin
            state_d = ST_LOAD;
            sel_d   = next_idx;
          end else begin
            state_d = ST_DONE;
          end
        end else if (expire) begin
          state_d     = ST_IDLE;
          timeout_set = 1'b1;
        end
      end
      ST_DONE: begin
        if (bus.mode[0] && next_found) begin
          mask_d  = bus.trigger_channel_mask;
          state_d = ST_LOAD;
          sel_d   = next_idx;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // ABORT overrides everything, including a coincident ser_done.
    if (abort_cmd && (state_q != ST_IDLE)) begin
      state_d     = ST_IDLE;
      mask_d      = mask_q;
      sel_d       = sel_q;
      timeout_set = 1'b0;
    end
  end

`ifdef SEQ_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] wait_cnt_q;
  logic             timeout_q;

  // wait_cnt_q equals the number of completed WAIT cycles in the current wait.
  assign expire = (state_q == ST_WAIT) && (wait_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge iclk) begin
    if (!rstn) begin
      wait_cnt_q <= '0;
      timeout_q  <= 1'b0;
    end else begin
      if (state_q == ST_WAIT) wait_cnt_q <= wait_cnt_q + CNT_W'(1);
      else                    wait_cnt_q <= '0;
      if (timeout_clr)      timeout_q <= 1'b0;
      else if (timeout_set) timeout_q <= 1'b1;
    end
  end

  assign bus.timeout_err = timeout_q;
  assign unused_ok       = ^bus.mode[7:1];
`else
  assign expire          = 1'b0;
  assign bus.timeout_err = 1'b0;
  assign unused_ok       = ^{bus.mode[7:1], timeout_set, timeout_clr, TIMEOUT_CYCLES[0]};
`endif

  assign bus.load_cnt_ser = (state_q == ST_LOAD) ? (NUM_CH'(1) << sel_q) : '0;
  assign bus.select_reg   = sel_q;
  assign bus.busy         = (state_q != ST_IDLE);
  assign bus.seq_done     = (state_q == ST_DONE);
  assign dbg_state        = state_q;

endmodule

// File: tb/tb_readout_sequencer.sv
// Directed bench for readout_sequencer; the timeout scenario runs when built
// with SEQ_TIMEOUT_EN, otherwise WAIT persistence is checked instead.
module tb_readout_sequencer;
  import psec5_seq_pkg::*;

`ifdef SEQ_TIMEOUT_EN
  localparam int TO = 4;
`else
  localparam int TO = 255;
`endif

  logic       iclk;
  logic       rstn;
  seq_state_e dbg_state;
  int         n_vec;
  int         n_err;
  logic [7:0] exp_q[$];

  readout_sequencer_if #(.NUM_CH(8)) bus ();

  readout_sequencer #(
    .NUM_CH         (8),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .iclk      (iclk),
    .rstn      (rstn),
    .bus       (bus.slave),
    .dbg_state (dbg_state)
  );

  // clock / reset
  initial begin
    iclk = 1'b0;
    forever #5 iclk = ~iclk;
  end

  task automatic check_vec(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // One clock with the given inputs held for that cycle; outputs are then
  // stable for sampling 1 time unit after the edge.
  task automatic cycle(input logic [7:0] op, input logic iv, input logic sd);
    bus.instruction = op;
    bus.instr_valid = iv;
    bus.ser_done    = sd;
    @(posedge iclk);
    #1;
    bus.instr_valid = 1'b0;
    bus.ser_done    = 1'b0;
    bus.instruction = 8'h00;
  endtask

  task automatic expect_state(input string tag, input seq_state_e st, input logic [7:0] load,
                              input logic [2:0] sel);
    check_vec({tag, "_state"}, 32'(dbg_state), 32'(st));
    check_vec({tag, "_load"}, 32'(bus.load_cnt_ser), 32'(load));
    check_vec({tag, "_sel"}, 32'(bus.select_reg), 32'(sel));
    check_vec({tag, "_busy"}, 32'(bus.busy), 32'(st != ST_IDLE));
    check_vec({tag, "_done"}, 32'(bus.seq_done), 32'(st == ST_DONE));
  endtask

  // scoreboard: every nonzero load strobe must match the next expected one
  always @(posedge iclk) begin
    #1;
    if (rstn && (bus.load_cnt_ser != 8'h00)) begin
      if (exp_q.size() == 0) check_vec("unexpected_load", 32'(bus.load_cnt_ser), 32'h0);
      else                   check_vec("load_order", 32'(bus.load_cnt_ser), 32'(exp_q.pop_front()));
    end
  end

  initial begin
    n_vec = 0;
    n_err = 0;
    rstn = 1'b0;
    bus.instruction = 8'h00;
    bus.instr_valid = 1'b0;
    bus.trigger_channel_mask = 8'h00;
    bus.mode = 8'h00;
    bus.ser_done = 1'b0;
    cycle(8'h00, 1'b0, 1'b0);
    cycle(OP_START, 1'b1, 1'b0);
    expect_state("reset", ST_IDLE, 8'h00, 3'd0);
    check_vec("reset_terr", 32'(bus.timeout_err), 32'h0);
    rstn = 1'b1;

    // mask 0b0101: channels 0 and 2; later mask change must not leak in
    bus.trigger_channel_mask = 8'h05;
    exp_q.push_back(8'h01);
    exp_q.push_back(8'h04);
    cycle(OP_START, 1'b1, 1'b0);
    expect_state("m05_load0", ST_LOAD, 8'h01, 3'd0);
    cycle(8'h00, 1'b0, 1'b0);
    expect_state("m05_wait0", ST_WAIT, 8'h00, 3'd0);
    bus.trigger_channel_mask = 8'hFF;
    cycle(8'h00, 1'b0, 1'b0);
    expect_state("m05_wait0b", ST_WAIT, 8'h00, 3'd0);
    cycle(8'h00, 1'b0, 1'b1);
    expect_state("m05_load2", ST_LOAD, 8'h04, 3'd2);
    cycle(8'h00, 1'b0, 1'b0);
    expect_state("m05_wait2", ST_WAIT, 8'h00, 3'd2);
    cycle(8'h00, 1'b0, 1'b1);
    expect_state("m05_done", ST_DONE, 8'h00, 3'd2);
    cycle(8'h00, 1'b0, 1'b0);
    expect_state("m05_idle", ST_IDLE, 8'h00, 3'd2);
    cycle(8'h00, 1'b0, 1'b1);
    expect_state("idle_serdone", ST_IDLE, 8'h00, 3'd2);

    // empty mask: straight to DONE
    bus.trigger_channel_mask = 8'h00;
    cycle(OP_START, 1'b1, 1'b0);
    expect_state("m00_done", ST_DONE, 8'h00, 3'd2);
    cycle(8'h00, 1'b0, 1'b0);
    expect_state("m00_idle", ST_IDLE, 8'h00, 3'd2);

    // unknown opcode and unqualified START are ignored
    bus.trigger_channel_mask = 8'h01;
    cycle(8'h03, 1'b1, 1'b0);
    expect_state("bad_op", ST_IDLE, 8'h00, 3'd2);
    cycle(OP_START, 1'b0, 1'b0);
    expect_state("no_valid", ST_IDLE, 8'h00, 3'd2);

    // mask FF, ABORT together with the third ser_done
    bus.trigger_channel_mask = 8'hFF;
    exp_q.push_back(8'h01);
    exp_q.push_back(8'h02);
    exp_q.push_back(8'h04);
    cycle(OP_START, 1'b1, 1'b0);
    expect_state("mff_load0", ST_LOAD, 8'h01, 3'd0);
    cycle(8'h00, 1'b0, 1'b0);
    cycle(8'h00, 1'b0, 1'b1);
    expect_state("mff_load1", ST_LOAD, 8'h02, 3'd1);
    cycle(8'h00, 1'b0, 1'b0);
    cycle(8'h00, 1'b0, 1'b1);
    expect_state("mff_load2", ST_LOAD, 8'h04, 3'd2);
    cycle(8'h00, 1'b0, 1'b0);
    cycle(OP_START, 1'b1, 1'b0);
    expect_state("mff_busy_start", ST_WAIT, 8'h00, 3'd2);
    cycle(OP_ABORT, 1'b1, 1'b1);
    expect_state("mff_abort", ST_IDLE, 8'h00, 3'd2);
    cycle(8'h00, 1'b0, 1'b0);
    expect_state("mff_after", ST_IDLE, 8'h00, 3'd2);
    cycle(OP_ABORT, 1'b1, 1'b0);
    expect_state("idle_abort", ST_IDLE, 8'h00, 3'd2);

    // continuous mode, single channel 7
    bus.mode = 8'h01;
    bus.trigger_channel_mask = 8'h80;
    exp_q.push_back(8'h80);
    exp_q.push_back(8'h80);
    cycle(OP_START, 1'b1, 1'b0);
    expect_state("cont_load", ST_LOAD, 8'h80, 3'd7);
    cycle(8'h00, 1'b0, 1'b0);
    cycle(8'h00, 1'b0, 1'b1);
    expect_state("cont_done", ST_DONE, 8'h00, 3'd7);
    cycle(8'h00, 1'b0, 1'b0);
    expect_state("cont_reload", ST_LOAD, 8'h80, 3'd7);
    bus.mode = 8'h00;
    cycle(8'h00, 1'b0, 1'b0);
    cycle(8'h00, 1'b0, 1'b1);
    expect_state("cont_done2", ST_DONE, 8'h00, 3'd7);
    cycle(8'h00, 1'b0, 1'b0);
    expect_state("cont_idle", ST_IDLE, 8'h00, 3'd7);

    // reset in the middle of a scan
    bus.trigger_channel_mask = 8'h0F;
    exp_q.push_back(8'h01);
    exp_q.push_back(8'h02);
    cycle(OP_START, 1'b1, 1'b0);
    cycle(8'h00, 1'b0, 1'b0);
    cycle(8'h00, 1'b0, 1'b1);
    cycle(8'h00, 1'b0, 1'b0);
    expect_state("rst_prewait", ST_WAIT, 8'h00, 3'd1);
    rstn = 1'b0;
    cycle(OP_START, 1'b1, 1'b1);
    expect_state("rst_mid", ST_IDLE, 8'h00, 3'd0);
    check_vec("rst_mid_terr", 32'(bus.timeout_err), 32'h0);
    rstn = 1'b1;
    exp_q.push_back(8'h01);
    cycle(OP_START, 1'b1, 1'b0);
    expect_state("rst_rescan", ST_LOAD, 8'h01, 3'd0);
    cycle(OP_ABORT, 1'b1, 1'b0);
    expect_state("rst_abort", ST_IDLE, 8'h00, 3'd0);

`ifdef SEQ_TIMEOUT_EN
    // watchdog: 4 WAIT cycles without ser_done, then IDLE with sticky error
    bus.trigger_channel_mask = 8'h01;
    exp_q.push_back(8'h01);
    cycle(OP_START, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) begin
      cycle(8'h00, 1'b0, 1'b0);
      expect_state("to_wait", ST_WAIT, 8'h00, 3'd0);
      check_vec("to_wait_terr", 32'(bus.timeout_err), 32'h0);
    end
    cycle(8'h00, 1'b0, 1'b0);
    expect_state("to_expired", ST_IDLE, 8'h00, 3'd0);
    check_vec("to_terr_set", 32'(bus.timeout_err), 32'h1);
    cycle(8'h00, 1'b0, 1'b0);
    check_vec("to_terr_sticky", 32'(bus.timeout_err), 32'h1);
    bus.trigger_channel_mask = 8'h00;
    cycle(OP_START, 1'b1, 1'b0);
    check_vec("to_terr_clear", 32'(bus.timeout_err), 32'h0);
    cycle(8'h00, 1'b0, 1'b0);
`else
    // no watchdog: WAIT persists until ser_done
    bus.trigger_channel_mask = 8'h01;
    exp_q.push_back(8'h01);
    cycle(OP_START, 1'b1, 1'b0);
    for (int i = 0; i < 20; i++) cycle(8'h00, 1'b0, 1'b0);
    expect_state("nto_wait", ST_WAIT, 8'h00, 3'd0);
    check_vec("nto_terr", 32'(bus.timeout_err), 32'h0);
    cycle(8'h00, 1'b0, 1'b1);
    expect_state("nto_done", ST_DONE, 8'h00, 3'd0);
    cycle(8'h00, 1'b0, 1'b0);
`endif
    expect_state("final_idle", ST_IDLE, 8'h00, 3'd0);
    check_vec("exp_q_empty", 32'(exp_q.size()), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/readout_sequencer.md
READOUT_SEQUENCER -- requirements
Module: readout_sequencer

Interface
REQ-001 SHALL have parameter NUM_CH, default 8, number of readout channels (select width = clog2(NUM_CH)).
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 255, maximum WAIT cycles before timeout (used only under REQ-025).
REQ-003 SHALL use one clock and a synchronous, active-low reset.
REQ-004 iclk  input  1  internal clock; all logic on posedge.
REQ-005 rstn  input  1  synchronous active-low reset.
REQ-006 instruction  input  8  opcode from SPI register map, address 2.
REQ-007 instr_valid  input  1  one-cycle strobe: instruction newly written.
REQ-008 trigger_channel_mask  input  8  channel enables from address 1; bit i = channel i.
REQ-009 mode  input  8  bit0 = continuous repeat; bits 7:1 ignored.
REQ-010 ser_done  input  1  serializer finished shifting the loaded word.
REQ-011 load_cnt_ser  output  8  one-hot load strobe for channel counter into serializer.
REQ-012 select_reg  output  3  channel currently being read out.
REQ-013 busy  output  1  high in any state other than IDLE.
REQ-014 seq_done  output  1  one-cycle pulse at end of a full scan.
REQ-015 timeout_err  output  1  sticky serializer-timeout flag.

Function
REQ-016 States SHALL be IDLE, LOAD, WAIT, DONE; opcodes START=8'h01, ABORT=8'h02; all other opcodes SHALL be ignored.
REQ-017 START with instr_valid in IDLE (cycle N) SHALL snapshot trigger_channel_mask and clear timeout_err; a later mask change SHALL not affect the scan in progress.
REQ-018 Channels SHALL be scanned in ascending order, skipping cleared bits in zero cycles; at N+1 the lowest enabled channel c is in LOAD with select_reg=c and load_cnt_ser=(1<<c) for exactly one cycle.
REQ-019 LOAD SHALL go to WAIT unconditionally; select_reg SHALL hold c through WAIT; load_cnt_ser SHALL be 0 outside LOAD.
REQ-020 ser_done in WAIT SHALL go, next cycle, to LOAD for the next enabled channel above c, or to DONE if none remain; ser_done in any other state SHALL be ignored.
REQ-021 DONE SHALL last one cycle with seq_done=1; it then goes to IDLE, or, if mode[0]=1 and the fresh mask is nonzero, re-snapshots the mask and goes to LOAD.
REQ-022 START with an all-zero snapshot SHALL go IDLE->DONE at N+1, with seq_done pulsed and no load strobe.
REQ-023 START while busy SHALL be ignored; ABORT in any state SHALL force IDLE next cycle with no seq_done; ABORT concurrent with ser_done SHALL win; ABORT in IDLE is a no-op.
REQ-024 select_reg SHALL hold its last value in IDLE.

Configuration
REQ-025 With SEQ_TIMEOUT_EN defined, a WAIT-cycle counter SHALL run; after TIMEOUT_CYCLES WAIT cycles without ser_done, timeout_err SHALL set (sticky) and the FSM SHALL go to IDLE with no seq_done; ser_done on the expiry cycle SHALL win.
REQ-026 Without SEQ_TIMEOUT_EN, no counter SHALL be built, timeout_err SHALL be tied 0, and WAIT SHALL persist until ser_done or ABORT.

Reset
REQ-027 rstn=0 at a posedge SHALL force IDLE, clear the mask snapshot and counter, and set load_cnt_ser=0, select_reg=0, busy=0, seq_done=0, timeout_err=0; mid-scan reset SHALL abandon the scan with no pulses.
REQ-028 No input SHALL be acted on during a cycle in which rstn=0.

Structure
REQ-029 Package psec5_seq_pkg SHALL hold the state enum, the START/ABORT opcode constants and NUM_CH default.
REQ-030 Sub-module chan_prio_find SHALL be combinational and return the lowest set mask bit strictly above a given index, plus a found flag.

Verification
REQ-031 mask=8'b0000_0101, START -> load_cnt_ser 8'h01 at N+1 (select 0); ser_done -> 8'h04 (select 2); ser_done -> seq_done pulse; busy drops.
REQ-032 mask=8'h00, START -> seq_done at N+1, load_cnt_ser never nonzero.
REQ-033 mask=8'hFF, ABORT asserted with the 3rd ser_done -> IDLE next cycle, no further loads, no seq_done.
REQ-034 mode=8'h01, mask=8'h80 -> load 8'h80, ser_done, seq_done, load 8'h80 again one cycle after DONE.
REQ-035 SEQ_TIMEOUT_EN, TIMEOUT_CYCLES=4, no ser_done -> timeout_err=1 after 4 WAIT cycles, IDLE; next START clears it.
REQ-036 rstn low mid-WAIT with mask=8'h0F -> all outputs 0 next cycle, START re-scan begins at channel 0.
